// File: rtl/fjmem_engine.sv
// fjmem_engine: parallel NOR flash access engine.
// Accepts READ/WRITE commands and runs each flash word through
// SETUP -> ACCESS -> HOLD phases. The phase lengths are programmable at runtime.
// Burst reads auto-increment the address and stream words through a
// single-entry, back-pressured response register. When the consumer is slow,
// the engine parks in STALL.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
// valid must not depend on ready. Once the response register is valid, its
// payload (rsp_data, rsp_last) holds steady until it is taken.
module fjmem_engine #(
  parameter int ADR_WIDTH  = 24,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADR_WIDTH-1:0]  cmd_adr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [3:0]            t_setup,
  input  logic [3:0]            t_access,
  input  logic [3:0]            t_hold,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_last,
  output logic                  cmd_err,
  output logic                  busy,
  output logic [ADR_WIDTH-1:0]  flash_adr,
  output logic [DATA_WIDTH-1:0] flash_d_o,
  output logic                  flash_d_oe,
  input  logic [DATA_WIDTH-1:0] flash_d_i,
  output logic                  flash_ce_n,
  output logic                  flash_oe_n,
  output logic                  flash_we_n,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    HOLD   = 3'd3,
    STALL  = 3'd4
  } state_t;

  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;

  state_t               state;
  logic                 is_write;
  logic [LEN_WIDTH-1:0] remaining;
  logic [3:0]           t_s, t_a, t_h;
  logic [3:0]           phase_cnt;
  logic                 rst_done;
  logic                 accept;
  logic                 rsp_take;

  // Hold cmd_ready low until one full clock has passed after reset is released.
  assign cmd_ready = rst_done && (state == IDLE) && !rsp_valid;
  assign accept    = cmd_valid && cmd_ready;
  assign rsp_take  = rsp_valid && rsp_ready;
  assign dbg_state = state;

  // Engine FSM: phase sequencing, flash pin registers and the response register.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      is_write   <= 1'b0;
      remaining  <= '0;
      t_s        <= '0;
      t_a        <= '0;
      t_h        <= '0;
      phase_cnt  <= '0;
      rst_done   <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_last   <= 1'b0;
      cmd_err    <= 1'b0;
      busy       <= 1'b0;
      flash_adr  <= '0;
      flash_d_o  <= '0;
      flash_d_oe <= 1'b0;
      flash_ce_n <= 1'b1;
      flash_oe_n <= 1'b1;
      flash_we_n <= 1'b1;
    end else begin
      rst_done <= 1'b1;
      cmd_err  <= 1'b0;
      // Consumer takes the word. The FSM below never loads a new word on the
      // same edge, because a new word is only captured after the slot is empty.
      if (rsp_take) rsp_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            if (cmd_op == OP_READ || cmd_op == OP_WRITE) begin
              is_write   <= (cmd_op == OP_WRITE);
              remaining  <= (cmd_op == OP_READ) ? cmd_len : '0;
              t_s        <= t_setup;
              t_a        <= t_access;
              t_h        <= t_hold;
              phase_cnt  <= '0;
              flash_adr  <= cmd_adr;
              flash_ce_n <= 1'b0;
              busy       <= 1'b1;
              state      <= SETUP;
              if (cmd_op == OP_WRITE) begin
                flash_d_o  <= cmd_wdata;
                flash_d_oe <= 1'b1;
              end
            end else begin
              cmd_err <= 1'b1;
            end
          end
        end

        SETUP: begin
          if (phase_cnt == t_s) begin
            phase_cnt <= '0;
            state     <= ACCESS;
            if (is_write) flash_we_n <= 1'b0;
            else          flash_oe_n <= 1'b0;
          end else begin
            phase_cnt <= phase_cnt + 4'd1;
          end
        end

        ACCESS: begin
          if (phase_cnt == t_a) begin
            phase_cnt  <= '0;
            state      <= HOLD;
            flash_oe_n <= 1'b1;
            flash_we_n <= 1'b1;
            if (!is_write) begin
              rsp_data  <= flash_d_i;
              rsp_valid <= 1'b1;
              rsp_last  <= (remaining == '0);
            end
          end else begin
            phase_cnt <= phase_cnt + 4'd1;
          end
        end

        HOLD: begin
          if (phase_cnt == t_h) begin
            phase_cnt <= '0;
            if (remaining == '0) begin
              state      <= IDLE;
              busy       <= 1'b0;
              flash_ce_n <= 1'b1;
              flash_d_oe <= 1'b0;
            end else if (!rsp_valid || rsp_take) begin
              state     <= SETUP;
              flash_adr <= flash_adr + ADR_WIDTH'(1);
              remaining <= remaining - LEN_WIDTH'(1);
            end else begin
              state      <= STALL;
              flash_ce_n <= 1'b1;
            end
          end else begin
            phase_cnt <= phase_cnt + 4'd1;
          end
        end

        STALL: begin
          // Resume the burst only once the parked word has been handed over.
          if (rsp_take) begin
            state      <= SETUP;
            flash_ce_n <= 1'b0;
            flash_adr  <= flash_adr + ADR_WIDTH'(1);
            remaining  <= remaining - LEN_WIDTH'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fjmem_engine.sv
// tb_fjmem_engine: self-checking bench for fjmem_engine.
// The flash model returns ~address truncated to the data width. Expected read
// words are queued when a command is issued and popped on each response handshake.
module tb_fjmem_engine;

  localparam int AW = 24;
  localparam int DW = 16;
  localparam int LW = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_ACCESS = 3'd2;
  localparam logic [2:0] ST_STALL  = 3'd4;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_adr;
  logic [LW-1:0] cmd_len;
  logic [DW-1:0] cmd_wdata;
  logic [3:0]    t_setup, t_access, t_hold;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_last;
  logic          cmd_err;
  logic          busy;
  logic [AW-1:0] flash_adr;
  logic [DW-1:0] flash_d_o;
  logic          flash_d_oe;
  logic [DW-1:0] flash_d_i;
  logic          flash_ce_n, flash_oe_n, flash_we_n;
  logic [2:0]    dbg_state;

  // scoreboard state
  logic [DW-1:0] exp_q[$];
  logic          exp_last_q[$];
  int            rsp_cyc[$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;
  bit            saw_stall;

  fjmem_engine #(.ADR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_adr(cmd_adr), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
    .t_setup(t_setup), .t_access(t_access), .t_hold(t_hold),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .cmd_err(cmd_err), .busy(busy),
    .flash_adr(flash_adr), .flash_d_o(flash_d_o), .flash_d_oe(flash_d_oe),
    .flash_d_i(flash_d_i), .flash_ce_n(flash_ce_n), .flash_oe_n(flash_oe_n),
    .flash_we_n(flash_we_n), .dbg_state(dbg_state)
  );

  // clock / flash model
  always #5 sys_clk = ~sys_clk;
  assign flash_d_i = ~flash_adr[DW-1:0];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Called once per cycle after inputs are final: records the handshake that
  // the coming rising edge performs.
  task automatic monitor();
    logic [DW-1:0] d;
    logic          l;
    if (sys_rst_n === 1'b1 && dbg_state === ST_STALL) saw_stall = 1'b1;
    if (sys_rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      rsp_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("rsp_extra_word", 32'(rsp_valid), 32'd0);
      end else begin
        d = exp_q.pop_front();
        l = exp_last_q.pop_front();
        check("rsp_data", 32'(rsp_data), 32'(d));
        check("rsp_last", 32'(rsp_last), 32'(l));
      end
    end
  endtask

  // One clock: monitor, then land at the next falling edge.
  task automatic tick();
    monitor();
    @(negedge sys_clk);
    cyc++;
  endtask

  task automatic push_read(input logic [AW-1:0] adr, input int len);
    logic [AW-1:0] a;
    for (int i = 0; i <= len; i++) begin
      a = adr + AW'(i);
      exp_q.push_back(~a[DW-1:0]);
      exp_last_q.push_back(i == len);
    end
  endtask

  // Returns at the falling edge of cycle 1 (the cycle after acceptance).
  task automatic send_cmd(input logic [1:0] op, input logic [AW-1:0] adr,
                          input logic [LW-1:0] len, input logic [DW-1:0] wd);
    int w;
    w = 0;
    cmd_op = op; cmd_adr = adr; cmd_len = len; cmd_wdata = wd; cmd_valid = 1'b1;
    while (!cmd_ready && w < 500) begin
      tick();
      w++;
    end
    if (!cmd_ready) check("cmd_accept", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input bit rnd);
    int w;
    w = 0;
    while ((exp_q.size() != 0 || busy || rsp_valid) && w < 3000) begin
      if (rnd) rsp_ready = 1'($urandom_range(0, 1));
      tick();
      w++;
    end
    rsp_ready = 1'b1;
    check("drain_left", 32'(exp_q.size()), 32'd0);
    check("drain_busy", 32'(busy), 32'd0);
  endtask

  int we_cnt, we_first, we_last, oe_cnt, oe_first, oe_last, oe_low;
  int rdy_first, busy_cnt, bad_do, c1, w, bad_stall;
  logic [1:0] rops [2];

  initial begin
    // reset with zero timings
    sys_rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_adr = '0; cmd_len = '0;
    cmd_wdata = '0; t_setup = '0; t_access = '0; t_hold = '0; rsp_ready = 1'b1;
    @(negedge sys_clk);
    repeat (3) tick();
    check("rst_ce_n", 32'(flash_ce_n), 32'd1);
    check("rst_oe_n", 32'(flash_oe_n), 32'd1);
    check("rst_we_n", 32'(flash_we_n), 32'd1);
    check("rst_d_oe", 32'(flash_d_oe), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    sys_rst_n = 1'b1;
    check("ready_at_release", 32'(cmd_ready), 32'd0);
    tick();
    check("ready_after_release", 32'(cmd_ready), 32'd1);

    // single WRITE, S=1 A=3 H=1
    t_setup = 4'd1; t_access = 4'd3; t_hold = 4'd1;
    send_cmd(2'b10, 24'h000123, 8'd0, 16'hBEEF);
    we_cnt = 0; we_first = -1; we_last = -1; oe_cnt = 0; oe_first = -1; oe_last = -1;
    oe_low = 0; rdy_first = -1; busy_cnt = 0; bad_do = 0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 1) begin
        check("wr_adr", 32'(flash_adr), 32'h000123);
        check("wr_ce_n_c1", 32'(flash_ce_n), 32'd0);
      end
      if (!flash_we_n) begin we_cnt++; if (we_first < 0) we_first = k; we_last = k; end
      if (flash_d_oe) begin oe_cnt++; if (oe_first < 0) oe_first = k; oe_last = k; end
      if (!flash_oe_n) oe_low++;
      if (flash_d_oe && flash_d_o !== 16'hBEEF) bad_do++;
      if (cmd_ready && rdy_first < 0) rdy_first = k;
      if (busy) busy_cnt++;
      tick();
    end
    check("wr_we_cnt", 32'(we_cnt), 32'd4);
    check("wr_we_first", 32'(we_first), 32'd3);
    check("wr_we_last", 32'(we_last), 32'd6);
    check("wr_doe_cnt", 32'(oe_cnt), 32'd8);
    check("wr_doe_first", 32'(oe_first), 32'd1);
    check("wr_doe_last", 32'(oe_last), 32'd8);
    check("wr_oe_n_low", 32'(oe_low), 32'd0);
    check("wr_d_o", 32'(bad_do), 32'd0);
    check("wr_ready_back", 32'(rdy_first), 32'd9);
    check("wr_busy_cnt", 32'(busy_cnt), 32'd8);

    // burst READ len=3 across the address wrap, consumer always ready
    t_setup = 4'd0; t_access = 4'd1; t_hold = 4'd1;
    rsp_ready = 1'b1; saw_stall = 1'b0; rsp_cyc.delete();
    push_read(24'hFFFFFE, 3);
    send_cmd(2'b01, 24'hFFFFFE, 8'd3, 16'h0);
    c1 = cyc;
    drain(1'b0);
    check("burst_words", 32'(rsp_cyc.size()), 32'd4);
    if (rsp_cyc.size() == 4) begin
      check("burst_first_lat", 32'(rsp_cyc[0] - c1), 32'd3);
      for (int i = 1; i < 4; i++) check("burst_pitch", 32'(rsp_cyc[i] - rsp_cyc[i-1]), 32'd5);
    end
    check("burst_no_stall", 32'(saw_stall), 32'd0);

    // same burst with the consumer stalled for 20 cycles after the first word
    rsp_ready = 1'b0; saw_stall = 1'b0; rsp_cyc.delete();
    push_read(24'hFFFFFE, 3);
    send_cmd(2'b01, 24'hFFFFFE, 8'd3, 16'h0);
    w = 0;
    while (!rsp_valid && w < 100) begin tick(); w++; end
    check("stall_first_valid", 32'(rsp_valid), 32'd1);
    bad_stall = 0;
    for (int k = 0; k < 20; k++) begin
      if (!rsp_valid || rsp_data !== exp_q[0] || rsp_last !== 1'b0) bad_stall++;
      tick();
    end
    check("stall_rsp_stable", 32'(bad_stall), 32'd0);
    check("stall_state", 32'(dbg_state), 32'(ST_STALL));
    check("stall_ce_n", 32'(flash_ce_n), 32'd1);
    check("stall_strobes", 32'({flash_oe_n, flash_we_n}), 32'd3);
    rsp_ready = 1'b1;
    tick();
    check("resume_state", 32'(dbg_state), 32'(ST_SETUP));
    check("resume_adr", 32'(flash_adr), 32'hFFFFFF);
    check("resume_ce_n", 32'(flash_ce_n), 32'd0);
    drain(1'b0);
    check("stall_words", 32'(rsp_cyc.size()), 32'd4);

    // reserved ops
    rops[0] = 2'b11; rops[1] = 2'b00;
    for (int i = 0; i < 2; i++) begin
      send_cmd(rops[i], 24'h000055, 8'd0, 16'h1234);
      check("rsv_err", 32'(cmd_err), 32'd1);
      check("rsv_busy", 32'(busy), 32'd0);
      check("rsv_ready", 32'(cmd_ready), 32'd1);
      check("rsv_pins", 32'({flash_ce_n, flash_oe_n, flash_we_n, flash_d_oe}), 32'hE);
      tick();
      check("rsv_err_clear", 32'(cmd_err), 32'd0);
      check("rsv_pins2", 32'({flash_ce_n, flash_oe_n, flash_we_n, flash_d_oe}), 32'hE);
    end

    // reset in the middle of a READ's ACCESS phase
    t_setup = 4'd1; t_access = 4'd5; t_hold = 4'd1;
    send_cmd(2'b01, 24'h000010, 8'd0, 16'h0);
    w = 0;
    while (dbg_state !== ST_ACCESS && w < 50) begin tick(); w++; end
    check("mid_in_access", 32'(dbg_state), 32'(ST_ACCESS));
    check("mid_oe_low", 32'(flash_oe_n), 32'd0);
    sys_rst_n = 1'b0;
    tick();
    check("mid_rst_oe_n", 32'(flash_oe_n), 32'd1);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ce_n", 32'(flash_ce_n), 32'd1);
    sys_rst_n = 1'b1;
    tick();
    t_setup = 4'd0; t_access = 4'd0; t_hold = 4'd0;
    rsp_cyc.delete();
    push_read(24'h000ABC, 1);
    send_cmd(2'b01, 24'h000ABC, 8'd1, 16'h0);
    drain(1'b0);
    check("post_rst_words", 32'(rsp_cyc.size()), 32'd2);

    // random reads with a randomly stalling consumer
    for (int i = 0; i < 6; i++) begin
      logic [AW-1:0] a;
      int            len;
      t_setup  = 4'($urandom_range(0, 3));
      t_access = 4'($urandom_range(0, 3));
      t_hold   = 4'($urandom_range(0, 3));
      a   = AW'($urandom_range(0, 1) ? 32'hFFFFFC + $urandom_range(0, 3) : $urandom_range(0, 32'hFFFFFF));
      len = $urandom_range(0, 4);
      push_read(a, len);
      send_cmd(2'b01, a, LW'(len), 16'h0);
      drain(1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
